// File: rtl/bcrypt_pkg.sv
// Shared types and codes for the bcrypt core scheduler.
package bcrypt_pkg;

    // Scheduler states; the encoding doubles as the host-visible phase value.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_STORE   = 3'd3,
        ST_FINISH  = 3'd4
    } sched_state_t;

    // Done words reported by a core when it finishes a phase step.
    localparam logic [31:0] DONE_LOADED   = 32'h0000_0001;
    localparam logic [31:0] DONE_COMPUTED = 32'h0000_0002;
    localparam logic [31:0] DONE_STORED   = 32'h0000_00FF;

    // Start words driven to a core; START_IDLE holds the core in reset.
    localparam logic [31:0] START_IDLE    = 32'd0;
    localparam logic [31:0] START_LOAD    = 32'd1;
    localparam logic [31:0] START_COMPUTE = 32'd2;
    localparam logic [31:0] START_STORE   = 32'd3;

    // Width of a core index; at least one bit so a single core still has a select.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcrypt_bram_mux.sv
// Routes the granted core's BRAM request onto the shared port A.
// Nothing reaches the port unless a grant is valid.
module bcrypt_bram_mux
    import bcrypt_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int C_SLV_DWIDTH = 32,
    parameter int C_MST_AWIDTH = 32,
    parameter int IDX_W        = idx_width(NUM_CORES)
) (
    input  logic                              grant_valid,
    input  logic [IDX_W-1:0]                  grant_idx,
    input  logic [NUM_CORES*4-1:0]            core_we,
    input  logic [NUM_CORES*C_MST_AWIDTH-1:0] core_addr,
    input  logic [NUM_CORES*C_SLV_DWIDTH-1:0] core_wrdata,
    output logic [3:0]                        bram_we,
    output logic [C_MST_AWIDTH-1:0]           bram_addr,
    output logic [C_SLV_DWIDTH-1:0]           bram_wrdata
);

    logic [3:0]              we_arr   [NUM_CORES];
    logic [C_MST_AWIDTH-1:0] addr_arr [NUM_CORES];
    logic [C_SLV_DWIDTH-1:0] data_arr [NUM_CORES];

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
        assign we_arr[k]   = core_we[k*4 +: 4];
        assign addr_arr[k] = core_addr[k*C_MST_AWIDTH +: C_MST_AWIDTH];
        assign data_arr[k] = core_wrdata[k*C_SLV_DWIDTH +: C_SLV_DWIDTH];
    end

    // Select the granted slice, otherwise park the port at all-zero.
    always_comb begin
        bram_we     = '0;
        bram_addr   = '0;
        bram_wrdata = '0;
        if (grant_valid && (int'(grant_idx) < NUM_CORES)) begin
            bram_we     = we_arr[grant_idx];
            bram_addr   = addr_arr[grant_idx];
            bram_wrdata = data_arr[grant_idx];
        end
    end

endmodule

// File: rtl/bcrypt_sched.sv
// Job scheduler for a bank of bcrypt_loop cores sharing one BRAM port.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for host_go; all cores held in reset (start=0)
// ST_LOAD    | cores loaded one at a time, ascending, with exclusive BRAM
// ST_COMPUTE | all active cores run together, no BRAM access
// ST_STORE   | cores stored one at a time, ascending, with exclusive BRAM
// ST_FINISH  | one cycle: starts dropped, host_done unless watchdog fired
module bcrypt_sched
    import bcrypt_pkg::*;
#(
    parameter int                   NUM_CORES      = 4,
    parameter int                   C_SLV_DWIDTH   = 32,
    parameter int                   C_MST_AWIDTH   = 32,
    parameter int                   TIMEOUT_W      = 32,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(32'hFFFF_FFF0)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              host_go,
    input  logic [NUM_CORES-1:0]              active_mask,
    output logic                              host_busy,
    output logic                              host_done,
    output logic                              host_error,
    output logic [2:0]                        phase,
    output logic [NUM_CORES*C_SLV_DWIDTH-1:0] core_start,
    input  logic [NUM_CORES*C_SLV_DWIDTH-1:0] core_done,
    input  logic [NUM_CORES*4-1:0]            core_we,
    input  logic [NUM_CORES*C_MST_AWIDTH-1:0] core_addr,
    input  logic [NUM_CORES*C_SLV_DWIDTH-1:0] core_wrdata,
    output logic [NUM_CORES*C_SLV_DWIDTH-1:0] core_rddata,
    output logic [3:0]                        BRAM_WE_A,
    output logic [C_MST_AWIDTH-1:0]           BRAM_Addr_A,
    output logic [C_SLV_DWIDTH-1:0]           BRAM_WrData_A,
    input  logic [C_SLV_DWIDTH-1:0]           BRAM_RdData_A
);

    localparam int                   IDX_W   = idx_width(NUM_CORES);
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_CYCLES - 1'b1;

    sched_state_t            state_q, state_d;
    logic [NUM_CORES-1:0]    mask_q, mask_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic [TIMEOUT_W-1:0]    wd_q, wd_d;
    logic                    error_q, error_d;

    logic [C_SLV_DWIDTH-1:0] done_arr [NUM_CORES];
    logic [NUM_CORES-1:0]    sel_mask;
    logic                    next_found;
    logic [IDX_W-1:0]        next_idx;
    logic [IDX_W-1:0]        first_idx;
    logic                    all_computed;
    logic [C_SLV_DWIDTH-1:0] step_code;

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_done
        assign done_arr[k] = core_done[k*C_SLV_DWIDTH +: C_SLV_DWIDTH];
    end

    // The read port is shared, so every core sees the same read data.
    assign core_rddata = {NUM_CORES{BRAM_RdData_A}};

    // In IDLE the first grant must come from the mask being accepted this cycle.
    assign sel_mask = (state_q == ST_IDLE) ? active_mask : mask_q;

    // Priority encoders: lowest active core overall, and lowest one above the current grant.
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (sel_mask[k]) begin
                first_idx = IDX_W'(k);
            end
            if (mask_q[k] && (IDX_W'(k) > grant_idx_q)) begin
                next_idx   = IDX_W'(k);
                next_found = 1'b1;
            end
        end
    end

    // Compute ends only when every active core shows its compute-done word at once.
    always_comb begin
        all_computed = 1'b1;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (mask_q[k] && (done_arr[k] != C_SLV_DWIDTH'(DONE_COMPUTED))) begin
                all_computed = 1'b0;
            end
        end
    end

    // Next-state logic for sequencing, grants and the per-step watchdog.
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        wd_d          = '0;
        error_d       = error_q;
        step_code     = (state_q == ST_STORE) ? C_SLV_DWIDTH'(DONE_STORED)
                                              : C_SLV_DWIDTH'(DONE_LOADED);
        case (state_q)
            ST_IDLE: begin
                grant_valid_d = 1'b0;
                if (host_go) begin
                    mask_d  = active_mask;
                    error_d = 1'b0;
                    if (active_mask == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d       = ST_LOAD;
                        grant_idx_d   = first_idx;
                        grant_valid_d = 1'b1;
                    end
                end
            end
            ST_LOAD, ST_STORE: begin
                wd_d = wd_q + 1'b1;
                if (grant_valid_q && (done_arr[grant_idx_q] == step_code)) begin
                    // Drop the grant for one cycle so two cores never overlap on the port.
                    grant_valid_d = 1'b0;
                    wd_d          = '0;
                end else if (wd_q == WD_LAST) begin
                    error_d       = 1'b1;
                    grant_valid_d = 1'b0;
                    state_d       = ST_FINISH;
                end else if (!grant_valid_q) begin
                    if (next_found) begin
                        grant_idx_d   = next_idx;
                        grant_valid_d = 1'b1;
                    end else begin
                        wd_d    = '0;
                        state_d = (state_q == ST_LOAD) ? ST_COMPUTE : ST_FINISH;
                    end
                end
            end
            ST_COMPUTE: begin
                wd_d = wd_q + 1'b1;
                if (all_computed) begin
                    state_d       = ST_STORE;
                    grant_idx_d   = first_idx;
                    grant_valid_d = 1'b1;
                    wd_d          = '0;
                end else if (wd_q == WD_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State and job registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            wd_q          <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            wd_q          <= wd_d;
            error_q       <= error_d;
        end
    end

    // Start words: finished cores keep their code so they are not reset by start=0.
    always_comb begin
        logic [31:0] sw;
        core_start = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            sw = START_IDLE;
            if (mask_q[k]) begin
                case (state_q)
                    ST_LOAD:    sw = (IDX_W'(k) <= grant_idx_q) ? START_LOAD : START_IDLE;
                    ST_COMPUTE: sw = START_COMPUTE;
                    ST_STORE:   sw = (IDX_W'(k) <= grant_idx_q) ? START_STORE : START_COMPUTE;
                    default:    sw = START_IDLE;
                endcase
            end
            core_start[k*C_SLV_DWIDTH +: C_SLV_DWIDTH] = C_SLV_DWIDTH'(sw);
        end
    end

    assign phase      = state_q;
    assign host_busy  = (state_q == ST_LOAD) || (state_q == ST_COMPUTE) || (state_q == ST_STORE);
    assign host_done  = (state_q == ST_FINISH) && !error_q;
    assign host_error = error_q;

    bcrypt_bram_mux #(
        .NUM_CORES    (NUM_CORES),
        .C_SLV_DWIDTH (C_SLV_DWIDTH),
        .C_MST_AWIDTH (C_MST_AWIDTH),
        .IDX_W        (IDX_W)
    ) u_bram_mux (
        .grant_valid (grant_valid_q),
        .grant_idx   (grant_idx_q),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wrdata (core_wrdata),
        .bram_we     (BRAM_WE_A),
        .bram_addr   (BRAM_Addr_A),
        .bram_wrdata (BRAM_WrData_A)
    );

endmodule

// File: tb/tb_bcrypt_sched.sv
// Bench for bcrypt_sched: behavioural core models plus a port-ownership model.
module tb_bcrypt_sched;

    localparam int NC = 4;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            host_go = 1'b0;
    logic [NC-1:0]   active_mask = '0;
    logic            host_busy, host_done, host_error;
    logic [2:0]      phase;
    logic [NC*32-1:0] core_start, core_rddata;
    logic [NC*32-1:0] core_done = '0;
    logic [NC*4-1:0]  core_we = '0;
    logic [NC*32-1:0] core_addr = '0;
    logic [NC*32-1:0] core_wrdata = '0;
    logic [3:0]      BRAM_WE_A;
    logic [31:0]     BRAM_Addr_A, BRAM_WrData_A;
    logic [31:0]     BRAM_RdData_A = '0;

    bcrypt_sched #(
        .NUM_CORES      (NC),
        .C_SLV_DWIDTH   (32),
        .C_MST_AWIDTH   (32),
        .TIMEOUT_W      (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_go       (host_go),
        .active_mask   (active_mask),
        .host_busy     (host_busy),
        .host_done     (host_done),
        .host_error    (host_error),
        .phase         (phase),
        .core_start    (core_start),
        .core_done     (core_done),
        .core_we       (core_we),
        .core_addr     (core_addr),
        .core_wrdata   (core_wrdata),
        .core_rddata   (core_rddata),
        .BRAM_WE_A     (BRAM_WE_A),
        .BRAM_Addr_A   (BRAM_Addr_A),
        .BRAM_WrData_A (BRAM_WrData_A),
        .BRAM_RdData_A (BRAM_RdData_A)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Core model parameters and state.
    int          dly_l [NC];
    int          dly_c [NC];
    int          dly_s [NC];
    bit          stuck [NC];
    logic [31:0] prev_st [NC];
    logic [31:0] done_w [NC];
    int          cnt [NC];

    // Monitor state.
    bit            mon_en = 1'b0;
    logic [NC-1:0] job_mask = '0;
    int            seq [$];
    int            prev_own = -1;
    int            done_pulses = 0;
    int            owners, own, n_one, n_two, n_three;
    logic [31:0]   s, d;
    logic [67:0]   exp_port;

    function automatic logic [31:0] st(input int k);
        return core_start[k*32 +: 32];
    endfunction

    function automatic int lowest(input logic [NC-1:0] m);
        for (int k = 0; k < NC; k++) if (m[k]) return k;
        return 0;
    endfunction

    // Check the port and start words, then advance the core models.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            owners = 0;
            own = -1;
            n_one = 0;
            n_two = 0;
            n_three = 0;
            for (int k = 0; k < NC; k++) begin
                s = st(k);
                d = core_done[k*32 +: 32];
                if ((s == 32'd1 && d != 32'd1) || (s == 32'd3 && d != 32'hFF)) begin
                    owners++;
                    own = k;
                end
                if (s == 32'd1) n_one++;
                if (s == 32'd2) n_two++;
                if (s == 32'd3) n_three++;
                if (!job_mask[k]) chk("inactive_start_zero", s, 0);
            end
            chk("bram_exclusive", owners <= 1, 1);
            exp_port = '0;
            if (owners == 1)
                exp_port = {core_we[own*4 +: 4], core_addr[own*32 +: 32], core_wrdata[own*32 +: 32]};
            chk("bram_port", {BRAM_WE_A, BRAM_Addr_A, BRAM_WrData_A}, exp_port);
            chk("rddata_bcast", core_rddata, {NC{BRAM_RdData_A}});
            chk("no_mixed_load_compute", (n_one > 0) && (n_two > 0), 0);
            if (n_two > 0 && n_one == 0 && n_three == 0)
                chk("compute_all_together", n_two, $countones(job_mask));
            if (owners == 1 && own != prev_own) seq.push_back(int'(st(own)) * 16 + own);
            prev_own = (owners == 1) ? own : -1;
            if (host_done) done_pulses++;
        end
        for (int k = 0; k < NC; k++) begin
            s = st(k);
            if (s != prev_st[k]) begin
                prev_st[k] = s;
                if (s == 0) done_w[k] = 0;
                cnt[k] = (s == 1) ? dly_l[k] : (s == 2) ? dly_c[k] : (s == 3) ? dly_s[k] : 0;
            end else if (s != 0 && cnt[k] > 0) begin
                cnt[k]--;
                if (cnt[k] == 0 && !(s == 2 && stuck[k]))
                    done_w[k] = (s == 1) ? 32'd1 : (s == 2) ? 32'd2 : 32'hFF;
            end
            core_done[k*32 +: 32]   = done_w[k];
            core_we[k*4 +: 4]       = job_mask[k] ? 4'($urandom) : 4'hF;
            core_addr[k*32 +: 32]   = $urandom;
            core_wrdata[k*32 +: 32] = $urandom;
        end
        BRAM_RdData_A = $urandom;
    end

    task automatic set_delays(input bit rnd);
        for (int k = 0; k < NC; k++) begin
            dly_l[k] = rnd ? int'($urandom_range(1, 8))  : 5;
            dly_c[k] = rnd ? int'($urandom_range(3, 30)) : 20;
            dly_s[k] = rnd ? int'($urandom_range(1, 8))  : 7;
            stuck[k] = 1'b0;
        end
    endtask

    task automatic check_idle_outputs();
        chk("rst_phase", phase, 0);
        chk("rst_busy", host_busy, 0);
        chk("rst_done", host_done, 0);
        chk("rst_error", host_error, 0);
        chk("rst_starts", core_start, 0);
        chk("rst_bram_we", BRAM_WE_A, 0);
        chk("rst_bram_addr", BRAM_Addr_A, 0);
    endtask

    // One full job; expectations come from the mask alone.
    task automatic run_job(input logic [NC-1:0] m, input bit exp_err, input bit mid_go);
        int q_exp [$];
        int n;
        int comp_cycles;
        bit gone;
        seq.delete();
        prev_own = -1;
        done_pulses = 0;
        gone = 1'b0;
        @(negedge clk);
        active_mask = m;
        job_mask = m;
        host_go = 1'b1;
        @(negedge clk);
        host_go = 1'b0;
        active_mask = NC'($urandom);
        chk("error_cleared_on_go", host_error, 0);
        if (m == 0) begin
            chk("zero_mask_done_latency", host_done, 1);
        end else begin
            chk("first_start_latency", st(lowest(m)), 1);
            chk("busy_after_go", host_busy, 1);
        end
        n = 0;
        comp_cycles = 0;
        while (phase != 3'd0 && n < 5000) begin
            host_go = 1'b0;
            if (mid_go && phase == 3'd1 && !gone) begin
                host_go = 1'b1;
                active_mask = ~m;
                gone = 1'b1;
            end
            if (phase == 3'd2) comp_cycles++;
            if (phase == 3'd4) begin
                chk("finish_done", host_done, !exp_err);
                chk("finish_error", host_error, exp_err);
                chk("finish_busy", host_busy, 0);
                chk("finish_starts", core_start, 0);
            end
            @(negedge clk);
            n++;
        end
        host_go = 1'b0;
        chk("job_terminates", n < 5000, 1);
        chk("idle_starts", core_start, 0);
        chk("idle_busy", host_busy, 0);
        chk("done_pulses", done_pulses, exp_err ? 0 : 1);
        chk("error_sticky", host_error, exp_err);
        if (exp_err) chk("watchdog_window", (comp_cycles >= TO - 2) && (comp_cycles <= TO + 2), 1);
        for (int k = 0; k < NC; k++) if (m[k]) q_exp.push_back(16 + k);
        if (!exp_err) for (int k = 0; k < NC; k++) if (m[k]) q_exp.push_back(48 + k);
        chk("grant_seq_len", seq.size(), q_exp.size());
        for (int i = 0; i < seq.size() && i < q_exp.size(); i++)
            chk("grant_order", seq[i], q_exp[i]);
    endtask

    task automatic reset_mid_store();
        int n;
        n = 0;
        @(negedge clk);
        job_mask = '1;
        active_mask = '1;
        host_go = 1'b1;
        @(negedge clk);
        host_go = 1'b0;
        while (phase != 3'd3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_store", phase, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs();
        rst = 1'b0;
    endtask

    initial begin
        logic [NC-1:0] m;
        for (int k = 0; k < NC; k++) begin
            prev_st[k] = '0;
            done_w[k] = '0;
            cnt[k] = 0;
        end
        set_delays(1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs();
        rst = 1'b0;
        mon_en = 1'b1;

        run_job(4'b1111, 1'b0, 1'b0);
        run_job(4'b1010, 1'b0, 1'b0);
        run_job(4'b0000, 1'b0, 1'b0);

        stuck[2] = 1'b1;
        run_job(4'b1111, 1'b1, 1'b0);
        stuck[2] = 1'b0;

        reset_mid_store();
        run_job(4'b1111, 1'b0, 1'b0);
        run_job(4'b0110, 1'b0, 1'b1);

        repeat (10) begin
            set_delays(1'b1);
            m = NC'($urandom_range(0, 15));
            run_job(m, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
